// File: rtl/uc_irq.sv
// uc_irq: monocycle CPU opcode decode plus a vectored, fixed-priority interrupt sequencer.
// Define UC_IRQ_EDGE_EN for edge-latched pending requests; otherwise requests are level-sensitive.
module uc_irq #(
  parameter int              N_IRQ      = 2,
  parameter int              VEC_W      = 10,
  parameter logic [VEC_W-1:0] VEC_BASE  = 10'h3F0,
  parameter int              VEC_STRIDE = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      opcode,
  input  logic             z,
  input  logic [N_IRQ-1:0] irq,
  output logic             s_inc,
  output logic             we3,
  output logic             wez,
  output logic             pop,
  output logic             push,
  output logic             s_stack,
  output logic             we4,
  output logic             we_out,
  output logic             timer_e,
  output logic             s_mem,
  output logic [1:0]       s_inm,
  output logic [1:0]       s_in,
  output logic [1:0]       s_out,
  output logic [2:0]       op_alu,
  output logic             s_vec,
  output logic             push_cur,
  output logic [VEC_W-1:0] vec_addr,
  output logic [N_IRQ-1:0] irq_ack,
  output logic             ie,
  output logic             in_isr
);

  localparam logic [0:0] ST_RUN = 1'b0;
  localparam logic [0:0] ST_ISR = 1'b1;

  logic             r_ie;
  logic [N_IRQ-1:0] r_mask;
  logic [0:0]       r_state;

  logic [N_IRQ-1:0] w_pend;
  logic [N_IRQ-1:0] w_act;
  logic [N_IRQ-1:0] w_sel;
  logic [N_IRQ-1:0] w_clr;
  logic [2:0]       w_win;
  logic             w_any;
  logic             w_take;
  logic             w_ei;
  logic             w_di;
  logic             w_reti;
  logic             w_mask_wr;
  logic             w_unused;

  assign w_unused = ^opcode[7:0];

`ifdef UC_IRQ_EDGE_EN
  logic [N_IRQ-1:0] r_pend;
  logic [N_IRQ-1:0] r_irq_q;

  // A new rising edge in the take cycle beats the clear, so that request is not lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend  <= '0;
      r_irq_q <= '0;
    end else begin
      r_irq_q <= irq;
      r_pend  <= (r_pend & ~w_clr) | (irq & ~r_irq_q);
    end
  end

  assign w_pend = r_pend;
`else
  assign w_pend = irq;
`endif

  assign w_act = w_pend & r_mask;
  assign w_any = |w_act;

  // Scan high to low so the lowest set index ends up as the winner.
  always_comb begin
    w_win = '0;
    w_sel = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (w_act[i]) begin
        w_win    = 3'(i);
        w_sel    = '0;
        w_sel[i] = 1'b1;
      end
    end
  end

  assign w_take   = reset & (r_state == ST_RUN) & r_ie & w_any;
  assign w_clr    = w_take ? w_sel : '0;
  assign vec_addr = w_any ? VEC_BASE + VEC_W'(VEC_STRIDE * int'(w_win)) : VEC_BASE;
  assign ie       = r_ie;
  assign in_isr   = (r_state == ST_ISR);

  always_comb begin
    s_inc     = 1'b1;
    we3       = 1'b0;
    wez       = 1'b0;
    pop       = 1'b0;
    push      = 1'b0;
    s_stack   = 1'b0;
    we4       = 1'b0;
    we_out    = 1'b0;
    timer_e   = 1'b0;
    s_mem     = 1'b0;
    s_inm     = 2'b00;
    s_in      = 2'b00;
    s_out     = 2'b00;
    op_alu    = 3'b000;
    s_vec     = 1'b0;
    push_cur  = 1'b0;
    irq_ack   = '0;
    w_ei      = 1'b0;
    w_di      = 1'b0;
    w_reti    = 1'b0;
    w_mask_wr = 1'b0;
    if (!reset) begin
      s_inc = 1'b1;
    end else if (w_take) begin
      // The fetched instruction is dropped; pushing the current PC re-runs it after RETI.
      push     = 1'b1;
      push_cur = 1'b1;
      s_inc    = 1'b0;
      s_vec    = 1'b1;
      irq_ack  = w_sel;
    end else begin
      casez (opcode[15:10])
        6'b0?????: begin we3 = 1'b1; wez = 1'b1; op_alu = opcode[12:10]; end
        6'b1000??: begin we3 = 1'b1; s_inm = 2'b01; end
        6'b100100: s_inc = 1'b0;
        6'b100101: s_inc = ~z;
        6'b100110: s_inc = z;
        6'b101000: begin pop = 1'b1; s_stack = 1'b1; s_inc = 1'b0; end
        6'b101001: push = 1'b1;
        6'b101010: begin we3 = 1'b1; s_inm = 2'b11; s_in = opcode[9:8]; end
        6'b101011: begin we_out = 1'b1; s_out = 2'b00; end
        6'b101100: begin we_out = 1'b1; s_out = 2'b01; end
        6'b1110??: begin we4 = 1'b1; s_mem = 1'b0; end
        6'b110000: begin we4 = 1'b1; s_mem = 1'b1; end
        6'b1111??: begin we3 = 1'b1; s_inm = 2'b10; end
        6'b101111: timer_e = 1'b1;
        6'b110001: w_ei = 1'b1;
        6'b110010: w_di = 1'b1;
        6'b110011: begin pop = 1'b1; s_stack = 1'b1; s_inc = 1'b0; w_reti = 1'b1; end
        6'b110100: w_mask_wr = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ie    <= 1'b0;
      r_mask  <= '1;
      r_state <= ST_RUN;
    end else if (w_take) begin
      r_ie    <= 1'b0;
      r_state <= ST_ISR;
    end else begin
      if (w_ei || w_reti) r_ie <= 1'b1;
      else if (w_di)      r_ie <= 1'b0;
      if (w_reti)    r_state <= ST_RUN;
      if (w_mask_wr) r_mask  <= opcode[N_IRQ-1:0];
    end
  end

endmodule

// File: doc/uc_irq.md
Name: uc_irq

Overview:
- Next-generation control unit for the monocycle CPU: the same opcode decode plus a parametrised vectored interrupt sequencer.
- Supports N_IRQ channels with a per-channel mask, a global enable, fixed priority and RETI.
- Sits between instruction memory (opcode field) and the datapath, PC mux and stack.
- Instruction decode uses opcode[15:10], the 6-bit major field.

Parameters:
N_IRQ, 2, number of interrupt channels (1..8)
VEC_W, 10, PC/vector width
VEC_BASE, 10'h3F0, address of channel-0 vector
VEC_STRIDE, 2, address spacing between consecutive vectors

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
opcode  in  16  current instruction
z  in  1  zero flag
irq  in  N_IRQ  interrupt requests, synchronous to clk
s_inc, we3, wez, pop, push, s_stack, we4, we_out, timer_e, s_mem  out  1 each  datapath controls, same meaning as the current unit
s_inm, s_in, s_out  out  2 each  datapath mux selects
op_alu  out  3  ALU operation
s_vec  out  1  1 = PC loads vec_addr
push_cur  out  1  1 = stack pushes current PC instead of PC+1
vec_addr  out  VEC_W  vector of the winning channel
irq_ack  out  N_IRQ  one-hot, asserted during the interrupt-take cycle
ie  out  1  global interrupt enable (registered)
in_isr  out  1  sequencer is in state ISR

Behaviour:
- Decode is combinational. Every output is assigned on every path: no latches, default 0, s_inc default 1.
- Existing decode map on opcode[15:10]:
  - 0zzzzz ALU: we3, wez; op_alu = opcode[12:10].
  - 1000zz load immediate: we3, s_inm=01.
  - 100100 jump: s_inc=0.
  - 100101 jump if z=1; 100110 jump if z=0.
  - 101000 return: pop, s_stack, s_inc=0.
  - 101001 call: push.
  - 101010 IN: we3, s_inm=11, s_in=opcode[9:8].
  - 101011 OUT from register: we_out, s_out=00.
  - 101100 OUT immediate: we_out, s_out=01.
  - 1110zz store, program addressing: we4, s_mem=0.
  - 110000 store, register addressing: we4, s_mem=1.
  - 1111zz load: we3, s_inm=10.
  - 101111 timer: timer_e.
- New opcodes:
  - 110001 EI: ie<=1.
  - 110010 DI: ie<=0.
  - 110011 RETI: pop, s_stack, s_inc=0; ie<=1, state<=RUN.
  - 110100 MASK: mask<=opcode[N_IRQ-1:0].
  - Unlisted opcodes decode as NOP.
- Registers: ie, mask[N_IRQ], pend[N_IRQ], irq_q[N_IRQ], state {RUN, ISR}.
- Reset values: ie=0, mask=all ones, pend=0, irq_q=0, state=RUN. While reset is low, every enable, s_vec and irq_ack is 0 and s_inc=1.
- Pending: pend[i] is set on an irq[i] rising edge (irq & ~irq_q).
- take = (state==RUN) & ie & |(pend & mask). Winner = lowest set index; index 0 has the highest priority.
- Take cycle:
  - Decode is fully overridden: we3, wez, we4, we_out, timer_e, pop = 0.
  - push=1, push_cur=1, s_inc=0, s_vec=1, irq_ack[winner]=1.
  - vec_addr = VEC_BASE + winner*VEC_STRIDE, truncated to VEC_W.
  - The suppressed instruction re-executes after RETI.
  - At the clock edge: pend[winner]<=0, ie<=0, state<=ISR.
- Boundary cases:
  - A new edge on the winning channel in the take cycle: the set wins and pend stays 1.
  - EI and DI take effect at the clock edge, so an interrupt is taken no earlier than the cycle after EI.
  - In ISR, interrupts are not taken even if EI is executed. They are taken after RETI.
  - RETI in RUN acts as a return and sets ie=1.
  - Masked pending bits are retained and fire when unmasked.
  - An asynchronous reset mid-ISR returns to RUN with pend cleared.
- vec_addr is driven with the winner's vector whenever any pend&mask bit is set; otherwise it is VEC_BASE.
- in_isr = (state==ISR).

Optional Feature:
- Macro UC_IRQ_EDGE_EN.
- Defined: edge-triggered pending latch as above.
- Undefined: level-sensitive.
  - pend = irq, combinationally; irq_q is unused.
  - The source must hold irq until irq_ack.
  - Nothing is stored. A request dropped before it is taken is lost.

Test Plan:
- Reset low with irq=2'b11 -> ie=0, pend=0, s_vec=0, irq_ack=0. After release, with EI not executed -> no take.
- EI, then an irq[1] rising edge while an ALU op is executing -> next cycle: s_vec=1, push=1, push_cur=1, we3=0, vec_addr=10'h3F2, irq_ack=2'b10. Following cycle: in_isr=1, ie=0.
- irq edges on channels 0 and 1 in the same cycle with ie=1 -> channel 0 taken first (vec 10'h3F0). After RETI -> channel 1 taken (vec 10'h3F2).
- MASK 2'b01, then an irq[1] edge -> no take, pend[1] held. MASK 2'b11 -> take on channel 1.
- In ISR: EI plus a new irq[0] edge -> no take. RETI -> pop=1, s_inc=0. Next cycle: take channel 0.
- Decode regression: opcode 16'h9400 (jump if z) with z=0 -> s_inc=1. Opcode 16'hBC00 -> timer_e=1, all other enables 0.
